// File: rtl/cpu_sb_pkg.sv
// Shared scoreboard defaults: register count, widths, pending-counter geometry.
package cpu_sb_pkg;
    localparam int SB_NREGS = 32;
    localparam int SB_AW    = 5;
    localparam int SB_DW    = 16;
    localparam int SB_NWP   = 2;
    localparam int SB_CW    = 2;
    localparam logic [SB_CW-1:0] SB_CMAX = 2'd3;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback-facing bundle of the register scoreboard.
interface reg_scoreboard_if
    import cpu_sb_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    parameter int NWP   = SB_NWP
);
    logic              iss_valid;
    logic              hold_in;
    logic              flush;
    logic [1:0]        src_re;
    logic [AW-1:0]     src_addr_0;
    logic [AW-1:0]     src_addr_1;
    logic [NWP-1:0]    dst_we;
    logic [NWP*AW-1:0] dst_addr;
    logic [NWP-1:0]    wb_we;
    logic [NWP*AW-1:0] wb_addr;
    logic [NWP*DW-1:0] wb_data;
    logic [DW-1:0]     rf_data_0;
    logic [DW-1:0]     rf_data_1;
    logic [DW-1:0]     opnd_0;
    logic [DW-1:0]     opnd_1;
    logic              issue_stall;
    logic [NREGS-1:0]  pending_mask;
    logic [15:0]       stall_cycles;
    logic              sb_err;

    modport master (
        output iss_valid, hold_in, flush, src_re, src_addr_0, src_addr_1,
               dst_we, dst_addr, wb_we, wb_addr, wb_data, rf_data_0, rf_data_1,
        input  opnd_0, opnd_1, issue_stall, pending_mask, stall_cycles, sb_err
    );

    modport slave (
        input  iss_valid, hold_in, flush, src_re, src_addr_0, src_addr_1,
               dst_we, dst_addr, wb_we, wb_addr, wb_data, rf_data_0, rf_data_1,
        output opnd_0, opnd_1, issue_stall, pending_mask, stall_cycles, sb_err
    );
endinterface

// File: rtl/sb_entry.sv
// One register's outstanding-write counter (0..3) with flush and underflow detect.
// Count and pending bit update one cycle after inc/dec; underflow is a same-cycle pulse.
module sb_entry
    import cpu_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [SB_CW-1:0] cnt,
    output logic             pend,
    output logic             underflow
);
    logic [SB_CW-1:0] cnt_nxt;

    // Flush wins over everything and suppresses underflow reporting.
    always_comb begin
        cnt_nxt   = cnt;
        underflow = 1'b0;
        if (flush) begin
            cnt_nxt = '0;
        end else if (inc && !dec) begin
            if (cnt != SB_CMAX) cnt_nxt = cnt + SB_CW'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) underflow = 1'b1;
            else           cnt_nxt   = cnt - SB_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            pend <= |cnt_nxt;
        end
    end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes, stalls on RAW/structural hazards, forwards wb data.
// Operands and issue_stall are combinational; counters, mask, stall count and sb_err lag one cycle.
module reg_scoreboard
    import cpu_sb_pkg::*;
#(
    parameter int NREGS  = SB_NREGS,
    parameter int AW     = SB_AW,
    parameter int DW     = SB_DW,
    parameter int NWP    = SB_NWP,
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_scoreboard_if.slave sb
);
    logic [SB_CW-1:0] cnt [NREGS];
    logic [NREGS-1:0] dst_hit, dec, pend, underflow;
    logic [AW-1:0]    src_a [2];
    logic [DW-1:0]    rf_d  [2];
    logic [DW-1:0]    wb_sel[2];
    logic [DW-1:0]    opnd  [2];
    logic [1:0]       wb_hit, fwd, src_haz;
    logic             struct_haz, stall, accept;
    logic [15:0]      stall_cnt;
    logic             err;

    assign src_a[0] = sb.src_addr_0;
    assign src_a[1] = sb.src_addr_1;
    assign rf_d[0]  = sb.rf_data_0;
    assign rf_d[1]  = sb.rf_data_1;

    // Duplicate addresses across ports collapse into a single inc/dec.
    always_comb begin
        dst_hit = '0;
        dec     = '0;
        for (int p = 0; p < NWP; p++) begin
            if (sb.dst_we[p]) dst_hit[sb.dst_addr[p*AW +: AW]] = 1'b1;
            if (sb.wb_we[p])  dec[sb.wb_addr[p*AW +: AW]]     = 1'b1;
        end
    end

    // Last matching port wins, so the highest-index writeback supplies data.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wb_hit[i] = 1'b0;
            wb_sel[i] = rf_d[i];
            for (int p = 0; p < NWP; p++) begin
                if (sb.wb_we[p] && (sb.wb_addr[p*AW +: AW] == src_a[i])) begin
                    wb_hit[i] = 1'b1;
                    wb_sel[i] = sb.wb_data[p*DW +: DW];
                end
            end
            fwd[i]     = (FWD_EN != 0) && wb_hit[i] && (cnt[src_a[i]] == SB_CW'(1));
            src_haz[i] = sb.src_re[i] && (cnt[src_a[i]] != '0) && !fwd[i];
            opnd[i]    = fwd[i] ? wb_sel[i] : rf_d[i];
        end
    end

    always_comb begin
        struct_haz = 1'b0;
        for (int p = 0; p < NWP; p++) begin
            if (sb.dst_we[p] && (cnt[sb.dst_addr[p*AW +: AW]] == SB_CMAX)
                && !dec[sb.dst_addr[p*AW +: AW]])
                struct_haz = 1'b1;
        end
    end

    assign stall  = sb.iss_valid && ((|src_haz) || struct_haz);
    assign accept = sb.iss_valid && !stall && !sb.hold_in && !sb.flush;

    for (genvar r = 0; r < NREGS; r++) begin : g_entry
        sb_entry u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (dst_hit[r] && accept),
            .dec       (dec[r]),
            .flush     (sb.flush),
            .cnt       (cnt[r]),
            .pend      (pend[r]),
            .underflow (underflow[r])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (stall && !sb.hold_in && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (|underflow)
                err <= 1'b1;
        end
    end

    assign sb.opnd_0       = opnd[0];
    assign sb.opnd_1       = opnd[1];
    assign sb.issue_stall  = stall;
    assign sb.pending_mask = pend;
    assign sb.stall_cycles = stall_cnt;
    assign sb.sb_err       = err;
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREGS, default 32, number of architectural registers tracked.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DW, default 16, data width.
REQ-004 Parameter NWP, default 2, number of destination/writeback ports.
REQ-005 Parameter FWD_EN, default 1, enables same-cycle writeback forwarding.
REQ-006 Ports SHALL be as follows; one clock; reset is synchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- iss_valid  in  1  instruction present in decode
- hold_in  in  1  control/VPU stall; issue not accepted
- flush  in  1  kill all in-flight writes
- src_re  in  2  source read-enable per operand
- src_addr_0, src_addr_1  in  AW  source addresses
- dst_we  in  NWP  destination write-enable per port
- dst_addr  in  NWP*AW  destination addresses, packed
- wb_we  in  NWP  writeback strobe per port
- wb_addr  in  NWP*AW  writeback addresses, packed
- wb_data  in  NWP*DW  writeback data, packed
- rf_data_0, rf_data_1  in  DW  register-file read data
- opnd_0, opnd_1  out  DW  resolved operands
- issue_stall  out  1  hazard stall request
- pending_mask  out  NREGS  bit r = register r has pending writes
- stall_cycles  out  16  saturating hazard-stall count
- sb_err  out  1  sticky writeback-underflow flag

Function
REQ-007 Per-register 2-bit pending counter SHALL track outstanding writes (0..3).
REQ-008 Issue accepted = iss_valid & ~issue_stall & ~hold_in & ~flush; on acceptance, each enabled dst_addr counter SHALL increment, visible next cycle.
REQ-009 Identical dst addresses on multiple ports in one issue SHALL increment that counter once.
REQ-010 Each wb_we port SHALL decrement its addressed counter next cycle; duplicate wb addresses in one cycle decrement once, highest-index port supplies data.
REQ-011 Simultaneous increment and decrement of one register SHALL leave its counter unchanged.
REQ-012 Decrement of a zero counter SHALL leave it at 0 and set sb_err, held until reset.
REQ-013 Source i is hazardous when src_re[i] and its counter is nonzero, except when FWD_EN=1, the counter equals 1, and a wb port writes that address this cycle.
REQ-014 In the forwarding case, opnd_i SHALL equal the matching wb_data in the same cycle; otherwise opnd_i = rf_data_i (combinational, zero latency).
REQ-015 Issue SHALL be structurally hazardous when any enabled dst counter equals 3 and is not being decremented this cycle.
REQ-016 issue_stall = iss_valid & (any source hazard | structural hazard), combinational; src_re=0 operands never stall.
REQ-017 hold_in SHALL block increments only; decrements and issue_stall evaluation continue.
REQ-018 flush SHALL zero all counters next cycle, overriding same-cycle issue and writeback; wb during flush is not flagged in sb_err.
REQ-019 pending_mask[r] SHALL be the registered OR-reduction of counter r.
REQ-020 stall_cycles SHALL increment each cycle issue_stall=1 and hold_in=0, saturating at 16'hFFFF.

Reset
REQ-021 With rst_n=0 at a clk edge: all counters 0, pending_mask 0, stall_cycles 0, sb_err 0.
REQ-022 Reset SHALL override flush, issue and writeback; combinational outputs follow the inputs after reset.

Structure
REQ-023 Shared package cpu_sb_pkg SHALL hold default NREGS/AW/DW/NWP, counter width (2), and the counter maximum (3).
REQ-024 One sub-module sb_entry (one counter, inc/dec/flush/underflow logic) SHALL be instantiated NREGS times.

Verification
REQ-025 Issue dst R3 at t, src R3 at t+1, no wb -> issue_stall=1, pending_mask[3]=1, stall_cycles increments each cycle.
REQ-026 Pending R3 (count 1), wb port0 R3 data 16'hBEEF with src R3 read -> issue_stall=0, opnd_0=16'hBEEF same cycle; with FWD_EN=0 -> stall.
REQ-027 Three issues writing R5, then a fourth -> issue_stall=1 (structural); same cycle wb R5 -> stall clears, counter stays 3.
REQ-028 Wb R7 with counter 0 -> sb_err=1 next cycle and held; counter stays 0.
REQ-029 Counters nonzero, flush with simultaneous issue dst R2 and wb R4 -> next cycle pending_mask=0.
REQ-030 hold_in=1 with iss_valid dst R9 -> pending_mask[9] stays 0; src_re=2'b00 with pending source -> issue_stall=0.
